// File: rtl/edge_event_scheduler_pkg.sv
// rtl/edge_event_scheduler_pkg.sv - shared types and constants for the edge event scheduler
//
// Purpose: FSM state encoding and default source count shared by the
//          scheduler top and its round-robin arbiter.
// Ports:   none (package).
package edge_sched_pkg;

  localparam int DEFAULT_NUM_SRC = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/edge_event_scheduler_rr_arbiter.sv
// rtl/edge_event_scheduler_rr_arbiter.sv - combinational round-robin grant
//
// Purpose: picks the lowest requesting index at or above ptr_i, wrapping
//          back to index 0 when nothing at or above ptr_i is requesting.
// Ports:   req_i       - request vector, one bit per source
//          ptr_i       - round-robin start index
//          gnt_valid_o - at least one request is set
//          gnt_id_o    - granted index (0 when gnt_valid_o is low)
module rr_arbiter
  import edge_sched_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic               gnt_valid_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  int               pos;
  logic [ID_W-1:0]  idx;

  // Scan NUM_SRC slots starting at ptr_i; the first hit in scan order wins,
  // which gives "lowest index >= ptr, then wrap to 0".
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_id_o    = '0;
    pos         = 0;
    idx         = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= NUM_SRC) begin
        pos = pos - NUM_SRC;
      end
      idx = ID_W'(pos);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_id_o    = idx;
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// rtl/edge_event_scheduler.sv - falling-edge capture with round-robin event presentation
//
// Purpose: captures falling edges on NUM_SRC lines into a pending vector,
//          presents one pending, unmasked line at a time with a valid/ready
//          handshake, and flags edges that hit an already-pending line.
// Ports:   clk, reset     - clock, asynchronous active-high reset
//          data_i         - monitored lines
//          mask_i         - per-line arbitration enable
//          clr_ovf_i      - clears overflow_o
//          evt_ready_i    - consumer accepts the presented event
//          evt_valid_o    - event presented
//          evt_id_o       - index of presented line
//          pending_o      - pending-edge vector
//          overflow_o     - sticky overflow flag
module edge_event_scheduler
  import edge_sched_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] data_i,
  input  logic [NUM_SRC-1:0] mask_i,
  input  logic               clr_ovf_i,
  input  logic               evt_ready_i,
  output logic               evt_valid_o,
  output logic [ID_W-1:0]    evt_id_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               overflow_o
);

  logic [NUM_SRC-1:0] data_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] edge_det;
  logic [NUM_SRC-1:0] hs_clr;
  logic [NUM_SRC-1:0] req;
  logic               overflow_q, overflow_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               handshake;
  state_e             state_q, state_d;

  assign edge_det  = data_q & ~data_i;
  assign handshake = (state_q == PRESENT) && evt_ready_i;
  assign hs_clr    = handshake ? (NUM_SRC'(1) << evt_id_q) : '0;

  // Clear first, then OR in new edges so a same-cycle edge keeps the line pending.
  assign pending_d = (pending_q & ~hs_clr) | edge_det;

  // New overflow is ORed after the clear so it wins over clr_ovf_i.
  assign overflow_d = (|(edge_det & pending_q)) | (overflow_q & ~clr_ovf_i);

  // Arbitrate on registered pending only; mask never affects capture.
  assign req = pending_q & mask_i;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
      evt_id_q   <= '0;
      rr_ptr_q   <= '0;
    end else begin
      data_q     <= data_i;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      evt_id_q   <= evt_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = PRESENT;
      PRESENT: if (evt_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and per-event register updates. The id is only loaded when
  // leaving IDLE, so nothing can disturb it while the event is presented.
  always_comb begin
    evt_valid_o = (state_q == PRESENT);
    evt_id_d    = evt_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == IDLE && gnt_valid) begin
      evt_id_d = gnt_id;
    end
    if (handshake) begin
      rr_ptr_d = (evt_id_q == ID_W'(NUM_SRC - 1)) ? '0 : evt_id_q + ID_W'(1);
    end
  end

  assign evt_id_o   = evt_id_q;
  assign pending_o  = pending_q;
  assign overflow_o = overflow_q;

endmodule
